// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter: payload width helpers,
// field offsets and the arbiter state encoding.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DATA  = 2'd2
   } arb_state_t;

   // arsize (3) + arburst (2) sit below arlen in the AR payload
   localparam int AR_TAIL_W  = 5;
   localparam int R_RESP_W   = 2;

   function automatic int idx_w(input int nm);
      return (nm < 2) ? 1 : $clog2(nm);
   endfunction

   function automatic int ar_w(input int id_w, input int addr_w, input int len_w);
      return id_w + addr_w + len_w + AR_TAIL_W;
   endfunction

   function automatic int r_w(input int id_w, input int data_w);
      return id_w + data_w + R_RESP_W;
   endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int NM = 2,
   parameter int IW = 1
) (
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] ptr,
   output logic [NM-1:0] grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   // scan from the farthest offset down so the closest requester is assigned last
   always_comb begin : pick
      int c;
      c   = 0;
      idx = '0;
      any = 1'b0;
      for (int k = NM - 1; k >= 0; k--) begin
         c = (int'(ptr) + k) % NM;
         if (req[c]) begin
            idx = IW'(c);
            any = 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < NM; gi++) begin : g_grant
      assign grant[gi] = any && (idx == IW'(gi));
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port between NM masters, one burst in flight at a time,
// widening ARID with the master index and steering R beats back to the owner.
module axi_read_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NM         = 2,
   parameter int ID_WIDTH   = 4,
   parameter int IDS_WIDTH  = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 4,
   localparam int IW    = idx_w(NM),
   localparam int AR_W  = ar_w(ID_WIDTH, ADDR_WIDTH, LEN_WIDTH),
   localparam int ARS_W = ar_w(IDS_WIDTH, ADDR_WIDTH, LEN_WIDTH),
   localparam int R_W   = r_w(ID_WIDTH, DATA_WIDTH),
   localparam int RS_W  = r_w(IDS_WIDTH, DATA_WIDTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NM*AR_W-1:0] m_ar_pld,
   input  logic [NM-1:0]     m_arvalid,
   output logic [NM-1:0]     m_arready,
   output logic [R_W-1:0]    m_r_pld,
   output logic              m_rlast,
   output logic [NM-1:0]     m_rvalid,
   input  logic [NM-1:0]     m_rready,
   output logic [ARS_W-1:0]  s_ar_pld,
   output logic              s_arvalid,
   input  logic              s_arready,
   input  logic [RS_W-1:0]   s_r_pld,
   input  logic              s_rlast,
   input  logic              s_rvalid,
   output logic              s_rready
);

   arb_state_t             state_reg, state_next;
   logic [IW-1:0]          rr_ptr_reg, owner_reg, win_idx;
   logic [NM-1:0]          win_grant;
   logic                   win_any;
   logic [ARS_W-1:0]       pld_reg;
   logic [AR_W-1:0]        win_pld;
   logic [IDS_WIDTH-1:0]   win_sid;
   logic [IDS_WIDTH-ID_WIDTH-1:0] rid_hi_exp;
   logic                   ar_hs, in_data, r_last_hs;

   rr_arbiter #(.NM(NM), .IW(IW)) u_rr (
      .req   (m_arvalid),
      .ptr   (rr_ptr_reg),
      .grant (win_grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   // reset gates the grant so nothing handshakes while reset is held
   assign ar_hs     = reset && (state_reg == IDLE) && win_any;
   assign m_arready = ar_hs ? win_grant : '0;
   assign win_pld   = m_ar_pld[win_idx*AR_W +: AR_W];

   always_comb begin
      win_sid = '0;
      win_sid[ID_WIDTH-1:0]   = win_pld[AR_W-1 -: ID_WIDTH];
      win_sid[ID_WIDTH +: IW] = win_idx;
   end

   assign s_arvalid = (state_reg == ISSUE);
   assign s_ar_pld  = pld_reg;

   assign in_data   = (state_reg == DATA);
   assign s_rready  = in_data && m_rready[owner_reg];
   assign m_rvalid  = in_data ? (NM'(s_rvalid) << owner_reg) : '0;
   assign m_rlast   = in_data && s_rlast;
   assign m_r_pld   = {s_r_pld[DATA_WIDTH+R_RESP_W +: ID_WIDTH], s_r_pld[DATA_WIDTH+R_RESP_W-1:0]};
   assign r_last_hs = in_data && s_rvalid && s_rready && s_rlast;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (ar_hs)     state_next = ISSUE;
         ISSUE:   if (s_arready) state_next = DATA;
         DATA:    if (r_last_hs) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         owner_reg  <= '0;
         pld_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (ar_hs) begin
            owner_reg <= win_idx;
            pld_reg   <= {win_sid, win_pld[AR_W-ID_WIDTH-1:0]};
         end
         if (r_last_hs)
            rr_ptr_reg <= (owner_reg == IW'(NM - 1)) ? '0 : owner_reg + 1'b1;
      end
   end

   // routing trusts owner_reg; a returned RID naming another master is a slave bug
   assign rid_hi_exp = (IDS_WIDTH-ID_WIDTH)'(owner_reg);
   always_ff @(posedge clock)
      if (reset && in_data && s_rvalid)
         assert (s_r_pld[RS_W-1 -: IDS_WIDTH-ID_WIDTH] == rid_hi_exp);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench: directed scenarios plus randomized bursts against a
// round-robin reference model.
module tb_axi_read_arbiter;
   localparam int NM = 2, IDW = 4, IDSW = 8, AW = 16, DW = 32, LW = 4;
   localparam int AR_W  = IDW + AW + LW + 5;
   localparam int ARS_W = IDSW + AW + LW + 5;
   localparam int R_W   = IDW + DW + 2;
   localparam int RS_W  = IDSW + DW + 2;

   logic clock = 1'b0;
   logic reset;
   logic [NM*AR_W-1:0] m_ar_pld;
   logic [NM-1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
   logic [R_W-1:0]     m_r_pld;
   logic               m_rlast;
   logic [ARS_W-1:0]   s_ar_pld;
   logic               s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
   logic [RS_W-1:0]    s_r_pld;

   int tests = 0, fails = 0;
   int ptr_m = 0;

   axi_read_arbiter #(.NM(NM), .ID_WIDTH(IDW), .IDS_WIDTH(IDSW), .ADDR_WIDTH(AW),
                      .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clock(clock), .reset(reset),
      .m_ar_pld(m_ar_pld), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_r_pld(m_r_pld), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .s_ar_pld(s_ar_pld), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_r_pld(s_r_pld), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   function automatic logic [AR_W-1:0] mk_ar(logic [IDW-1:0] id, logic [AW-1:0] a, logic [LW-1:0] l);
      return {id, a, l, 3'b010, 2'b01};
   endfunction

   // slave-side AR: ARID is {pad, master index, master ARID}
   function automatic logic [ARS_W-1:0] exp_sar(int m, logic [AR_W-1:0] p);
      logic [IDSW-1:0] sid;
      sid = IDSW'(m * (1 << IDW) + int'(p[AR_W-1 -: IDW]));
      return {sid, p[AR_W-IDW-1:0]};
   endfunction

   function automatic logic [RS_W-1:0] mk_r(int m, logic [IDW-1:0] id, logic [DW-1:0] d, logic [1:0] rs);
      logic [IDSW-1:0] sid;
      sid = IDSW'(m * (1 << IDW) + int'(id));
      return {sid, d, rs};
   endfunction

   function automatic logic [NM-1:0] onehot(int w);
      logic [NM-1:0] r;
      r = '0;
      r[w] = 1'b1;
      return r;
   endfunction

   function automatic int rr_pick(logic [NM-1:0] req, int ptr);
      for (int k = 0; k < NM; k++)
         if (req[(ptr + k) % NM]) return (ptr + k) % NM;
      return -1;
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset_contention();
      reset = 1'b0; m_arvalid = '1; s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = '1; s_arready = 1'b1;
      for (int i = 0; i < NM; i++) m_ar_pld[i*AR_W +: AR_W] = mk_ar(IDW'(i + 1), AW'(16'h0100 * i), 4'd0);
      cyc(); cyc(); #1;
      tests++;
      if ({m_arready, s_arvalid, m_rvalid, s_rready, m_rlast} !== 7'b0) begin
         fails++;
         $display("FAIL reset_outputs got %b want 0000000", {m_arready, s_arvalid, m_rvalid, s_rready, m_rlast});
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; s_arready = 1'b0; reset = 1'b1; #1;
      for (int g = 0; g < 4; g++) begin
         int w;
         w = g % NM;
         tests++;
         if (m_arready !== onehot(w)) begin
            fails++; $display("FAIL contention_grant%0d got %b want %b", g, m_arready, onehot(w));
         end
         cyc(); #1;
         tests++;
         if ({s_arvalid, s_ar_pld} !== {1'b1, exp_sar(w, mk_ar(IDW'(w + 1), AW'(16'h0100 * w), 4'd0))}) begin
            fails++; $display("FAIL contention_sar%0d got %b/%h want master %0d", g, s_arvalid, s_ar_pld, w);
         end
         s_arready = 1'b1; cyc(); s_arready = 1'b0;
         s_rvalid = 1'b1; s_rlast = 1'b1; s_r_pld = mk_r(w, IDW'(w + 1), 32'($urandom), 2'b00); #1;
         tests++;
         if ({m_rvalid, m_arready} !== {onehot(w), 2'b00}) begin
            fails++; $display("FAIL contention_beat%0d got %b/%b want %b/00", g, m_rvalid, m_arready, onehot(w));
         end
         cyc(); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
         $display("[TB] contention burst %0d granted master %0d", g, w);
      end
      m_arvalid = '0;
      ptr_m = 0;
   endtask

   task automatic test_single();
      logic [DW-1:0] d;
      m_ar_pld[0 +: AR_W] = mk_ar(4'h3, 16'h0040, 4'd3); m_arvalid = 2'b01; #1;
      tests++;
      if (m_arready !== 2'b01) begin fails++; $display("FAIL single_arready got %b want 01", m_arready); end
      cyc(); m_arvalid = '0; #1;
      tests++;
      if ({s_arvalid, s_ar_pld} !== {1'b1, 8'h03, 16'h0040, 4'd3, 3'b010, 2'b01}) begin
         fails++; $display("FAIL single_sar got %b/%h want 1/%h", s_arvalid, s_ar_pld, {8'h03, 16'h0040, 4'd3, 3'b010, 2'b01});
      end
      s_arready = 1'b1; cyc(); s_arready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         d = 32'hA000_0000 + 32'(b);
         s_rvalid = 1'b1; s_rlast = (b == 3); s_r_pld = {8'h03, d, 2'b00}; m_rready = 2'b11; #1;
         tests++;
         if ({m_rvalid, s_rready, m_rlast, m_r_pld} !== {2'b01, 1'b1, (b == 3), 4'h3, d, 2'b00}) begin
            fails++; $display("FAIL single_beat%0d got %b %b %b %h", b, m_rvalid, s_rready, m_rlast, m_r_pld);
         end
         cyc();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m_arvalid = 2'b10; #1;
      tests++;
      if (m_arready !== 2'b10) begin fails++; $display("FAIL single_back_idle got %b want 10", m_arready); end
      m_arvalid = '0;
      ptr_m = 1;
      $display("[TB] single burst master 0 len 3 done");
   endtask

   task automatic test_backpressure();
      logic rr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [DW-1:0] d;
      int beat;
      m_ar_pld[AR_W +: AR_W] = mk_ar(4'h5, 16'h2000, 4'd1); m_arvalid = 2'b10; #1;
      tests++;
      if (m_arready !== 2'b10) begin fails++; $display("FAIL bp_arready got %b want 10", m_arready); end
      cyc(); m_arvalid = '0; #1;
      tests++;
      if (s_ar_pld !== {8'h15, 16'h2000, 4'd1, 3'b010, 2'b01}) begin
         fails++; $display("FAIL bp_sar got %h", s_ar_pld);
      end
      s_arready = 1'b1; cyc(); s_arready = 1'b0;
      beat = 0;
      for (int c = 0; c < 4; c++) begin
         d = (beat == 1) ? 32'hDEAD_BEEF : 32'h1234_5678;
         s_rvalid = 1'b1; s_rlast = (beat == 1); s_r_pld = {8'h15, d, 2'b00}; m_rready = {rr[c], 1'b1}; #1;
         tests++;
         if ({m_rvalid, s_rready, m_r_pld[DW+1:2]} !== {2'b10, rr[c], d}) begin
            fails++; $display("FAIL bp_cycle%0d got %b %b %h want 10 %b %h", c, m_rvalid, s_rready, m_r_pld[DW+1:2], rr[c], d);
         end
         if (rr[c]) beat++;
         cyc();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m_arvalid = 2'b01; #1;
      tests++;
      if (m_arready !== 2'b01) begin fails++; $display("FAIL bp_back_idle got %b want 01", m_arready); end
      m_arvalid = '0;
      ptr_m = 0;
      $display("[TB] backpressure burst master 1 len 1 done");
   endtask

   task automatic test_slave_stall();
      logic [ARS_W-1:0] e;
      e = {8'h07, 16'h1234, 4'd0, 3'b010, 2'b01};
      m_ar_pld[0 +: AR_W] = mk_ar(4'h7, 16'h1234, 4'd0); m_arvalid = 2'b01; #1;
      cyc(); m_arvalid = '0; s_rvalid = 1'b1; m_rready = 2'b11;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin m_arvalid = 2'b01; m_ar_pld[0 +: AR_W] = mk_ar(4'h8, 16'h5555, 4'd2); end
         #1;
         tests++;
         if ({s_arvalid, s_ar_pld, m_arready, s_rready, m_rvalid} !== {1'b1, e, 2'b00, 1'b0, 2'b00}) begin
            fails++; $display("FAIL stall_cycle%0d got %b %h %b %b %b", c, s_arvalid, s_ar_pld, m_arready, s_rready, m_rvalid);
         end
         cyc();
      end
      s_rvalid = 1'b0; s_arready = 1'b1; cyc(); s_arready = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b1; s_r_pld = {8'h07, 32'h0BAD_F00D, 2'b00}; #1;
      tests++;
      if ({m_rvalid, m_arready} !== 4'b0100) begin
         fails++; $display("FAIL stall_data got %b/%b want 01/00", m_rvalid, m_arready);
      end
      cyc(); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
      tests++;
      if (m_arready !== 2'b01) begin fails++; $display("FAIL stall_back_idle got %b want 01", m_arready); end
      m_arvalid = '0;
      ptr_m = 1;
      $display("[TB] slave stall burst master 0 done");
   endtask

   task automatic test_reset_mid_burst();
      m_ar_pld[0 +: AR_W] = mk_ar(4'h2, 16'h3000, 4'd3); m_arvalid = 2'b01; #1;
      cyc(); m_arvalid = '0; s_arready = 1'b1; #1; cyc(); s_arready = 1'b0;
      m_rready = 2'b11;
      for (int b = 0; b < 2; b++) begin
         s_rvalid = 1'b1; s_rlast = 1'b0; s_r_pld = {8'h02, 32'(b), 2'b00}; #1; cyc();
      end
      reset = 1'b0; m_arvalid = 2'b10; m_ar_pld[AR_W +: AR_W] = mk_ar(4'hC, 16'h4000, 4'd0);
      cyc(); #1;
      tests++;
      if ({m_arready, s_arvalid, m_rvalid, s_rready, m_rlast} !== 7'b0) begin
         fails++; $display("FAIL rst_mid_outputs got %b want 0000000", {m_arready, s_arvalid, m_rvalid, s_rready, m_rlast});
      end
      reset = 1'b1; s_rvalid = 1'b0; #1;
      tests++;
      if (m_arready !== 2'b10) begin fails++; $display("FAIL rst_mid_grant got %b want 10", m_arready); end
      cyc(); m_arvalid = '0; #1;
      tests++;
      if ({s_arvalid, s_ar_pld} !== {1'b1, 8'h1C, 16'h4000, 4'd0, 3'b010, 2'b01}) begin
         fails++; $display("FAIL rst_mid_sar got %b/%h", s_arvalid, s_ar_pld);
      end
      s_arready = 1'b1; cyc(); s_arready = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b1; s_r_pld = {8'h1C, 32'h0000_1111, 2'b00}; #1;
      tests++;
      if (m_rvalid !== 2'b10) begin fails++; $display("FAIL rst_mid_beat got %b want 10", m_rvalid); end
      cyc(); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
      ptr_m = 0;
      $display("[TB] reset mid-burst recovery master 1 done");
   endtask

   task automatic test_single_beat();
      m_ar_pld[AR_W +: AR_W] = mk_ar(4'h9, 16'hFFFC, 4'd0); m_arvalid = 2'b10; #1;
      cyc(); m_arvalid = '0; #1;
      tests++;
      if (s_ar_pld !== {8'h19, 16'hFFFC, 4'd0, 3'b010, 2'b01}) begin
         fails++; $display("FAIL len0_sar got %h", s_ar_pld);
      end
      s_arready = 1'b1; cyc(); s_arready = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b1; s_r_pld = {8'h19, 32'hCAFE_0001, 2'b00}; m_rready = 2'b10; #1;
      tests++;
      if ({m_rvalid, m_rlast, s_rready} !== 4'b1011) begin
         fails++; $display("FAIL len0_beat got %b %b %b want 10 1 1", m_rvalid, m_rlast, s_rready);
      end
      cyc(); #1;
      tests++;
      if ({m_rvalid, s_rready} !== 3'b000) begin
         fails++; $display("FAIL len0_after got %b %b want 00 0", m_rvalid, s_rready);
      end
      s_rvalid = 1'b0; s_rlast = 1'b0;
      ptr_m = 0;
      $display("[TB] single-beat burst master 1 addr FFFC done");
   endtask

   task automatic test_random();
      logic [NM-1:0]   pend;
      logic [AR_W-1:0] pend_pld [NM];
      logic [ARS_W-1:0] e;
      logic [IDW-1:0]  id;
      logic [DW-1:0]   d;
      logic [1:0]      rs;
      int win, len, beat, guard, stall;
      pend = '0;
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < NM; i++)
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               pend[i] = 1'b1;
               pend_pld[i] = mk_ar(IDW'($urandom), AW'($urandom), LW'($urandom_range(0, 3)));
            end
         if (pend == '0) begin
            pend[0] = 1'b1;
            pend_pld[0] = mk_ar(IDW'($urandom), AW'($urandom), LW'($urandom_range(0, 3)));
         end
         for (int i = 0; i < NM; i++) m_ar_pld[i*AR_W +: AR_W] = pend_pld[i];
         m_arvalid = pend;
         win = rr_pick(pend, ptr_m);
         #1;
         tests++;
         if (m_arready !== onehot(win)) begin
            fails++; $display("FAIL rand%0d_grant got %b want %b", n, m_arready, onehot(win));
         end
         cyc();
         e = exp_sar(win, pend_pld[win]);
         id = pend_pld[win][AR_W-1 -: IDW];
         len = int'(pend_pld[win][LW+4:5]);
         pend[win] = 1'b0;
         m_arvalid = pend;
         stall = $urandom_range(0, 3);
         for (int k = 0; k <= stall; k++) begin
            s_arready = (k == stall); #1;
            tests++;
            if ({s_arvalid, s_ar_pld, m_arready} !== {1'b1, e, 2'b00}) begin
               fails++; $display("FAIL rand%0d_issue got %b %h %b want 1 %h 00", n, s_arvalid, s_ar_pld, m_arready, e);
            end
            cyc();
         end
         s_arready = 1'b0;
         beat = 0; guard = 0;
         while (beat <= len && guard < 200) begin
            d = 32'($urandom); rs = 2'($urandom);
            s_rvalid = ($urandom_range(0, 3) != 0); m_rready = NM'($urandom);
            s_rlast = (beat == len); s_r_pld = mk_r(win, id, d, rs); #1;
            tests++;
            if ({m_rvalid, s_rready} !== {(s_rvalid ? onehot(win) : 2'b00), m_rready[win]}) begin
               fails++; $display("FAIL rand%0d_route got %b %b want rv=%b rr=%b", n, m_rvalid, s_rready, s_rvalid, m_rready[win]);
            end
            if (s_rvalid) begin
               tests++;
               if ({m_r_pld, m_rlast} !== {id, d, rs, s_rlast}) begin
                  fails++; $display("FAIL rand%0d_payload got %h %b want %h %b", n, m_r_pld, m_rlast, {id, d, rs}, s_rlast);
               end
            end
            if (s_rvalid && m_rready[win]) beat++;
            cyc();
            guard++;
         end
         s_rvalid = 1'b0; s_rlast = 1'b0;
         tests++;
         if (guard >= 200) begin fails++; $display("FAIL rand%0d_timeout beats=%0d want %0d", n, beat, len + 1); end
         ptr_m = (win + 1) % NM;
         $display("[TB] random burst %0d master %0d len %0d stall %0d", n, win, len, stall);
      end
      m_arvalid = '0;
   endtask

   initial begin
      reset = 1'b0; m_ar_pld = '0; m_arvalid = '0; m_rready = '0;
      s_arready = 1'b0; s_r_pld = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
      test_reset_contention();
      test_single();
      test_backpressure();
      test_slave_stall();
      test_reset_mid_burst();
      test_single_beat();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single read port of the SRAM_wrapper AXI slave between NM read masters, for example instruction fetch and data load.
- Arbitrates AR requests round-robin and forwards one burst at a time to the slave.
- Steers the R beats back to the owning master.
- Widens the master ID (ID_WIDTH) to the slave ID (IDS_WIDTH) by prefixing the master index, matching the 4-bit-master / 8-bit-slave ID split used on the bus.

Parameters:
- NM, 2: number of read masters (2..4).
- ID_WIDTH, 4: master-side ARID/RID width.
- IDS_WIDTH, 8: slave-side ARID/RID width. Must be at least ID_WIDTH+clog2(NM).
- ADDR_WIDTH, 16: address width.
- DATA_WIDTH, 32: read data width.
- LEN_WIDTH, 4: ARLEN width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- m_ar_pld  in  NM*AR_W  per-master packed AR payload {arid, araddr, arlen, arsize, arburst}, with AR_W = ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+5.
- m_arvalid  in  NM  per-master ARVALID.
- m_arready  out  NM  per-master ARREADY.
- m_r_pld  out  R_W  R payload {rid, rdata, rresp}, broadcast to all masters, with R_W = ID_WIDTH+DATA_WIDTH+2.
- m_rlast  out  1  RLAST, broadcast.
- m_rvalid  out  NM  per-master RVALID; only the owner bit is ever set.
- m_rready  in  NM  per-master RREADY.
- s_ar_pld  out  ARS_W  slave AR payload, with arid widened to IDS_WIDTH.
- s_arvalid  out  1  slave ARVALID.
- s_arready  in  1  slave ARREADY.
- s_r_pld  in  RS_W  slave R payload {rid[IDS_WIDTH], rdata, rresp}.
- s_rlast  in  1  slave RLAST.
- s_rvalid  in  1  slave RVALID.
- s_rready  out  1  slave RREADY.

Behaviour:
Reset (reset==0 at a clock edge):
- State goes to IDLE, rr_ptr=0, owner=0, payload register cleared.
- m_arready=0, s_arvalid=0, m_rvalid=0, s_rready=0 from the first cycle reset is sampled low.
- Reset mid-burst abandons the burst. No R beat is forwarded after reset.

State machine: IDLE -> ISSUE -> DATA -> IDLE.

IDLE:
- Winner is the first i with m_arvalid[i], searching i = rr_ptr, rr_ptr+1, ... mod NM.
- m_arready[winner]=1 combinationally, and only while in IDLE. All other m_arready bits are 0.
- On the handshake: latch the winner payload and owner=winner, then go to ISSUE.
- No request: stay in IDLE.

ISSUE:
- s_arvalid=1 with the latched payload.
- s_arid = {zero-pad, owner[clog2(NM)-1:0], arid}.
- The payload is held stable until s_arready=1, then go to DATA.
- Latency: master AR handshake at cycle t gives s_arvalid high at t+1.

DATA:
- m_rvalid[owner]=s_rvalid. All other m_rvalid bits are 0.
- s_rready=m_rready[owner].
- m_r_pld = {s_rid[ID_WIDTH-1:0], s_rdata, s_rresp}. m_rlast=s_rlast.
- The beat path is purely combinational: zero added latency, no buffering.
- On s_rvalid & s_rready & s_rlast: go to IDLE and set rr_ptr=(owner+1) mod NM.

Ordering and boundary cases:
- Only one burst is outstanding at a time, so the slave returns beats in order.
- Routing uses the latched owner, not s_rid. A mismatch between s_rid index bits and owner is a protocol error, flagged by a simulation assertion only.
- ARLEN=0 (single beat) completes in DATA on the first beat.
- Back-to-back bursts: one IDLE cycle is inserted between the last R beat and the next AR grant.
- Simultaneous requests: exactly one grant per IDLE visit. A losing master keeps m_arvalid high and wins no later than NM-1 grants afterwards (starvation-free).
- m_arvalid rising in ISSUE or DATA is held off with m_arready=0 until IDLE.
- Slave beats with s_rvalid=1 while in IDLE or ISSUE are not acknowledged (s_rready=0).

Decomposition:
- Shared package axi_arb_pkg holds:
  - AR/R packed-payload widths and field offsets;
  - the idx_w function, clog2(NM);
  - the state enum {IDLE, ISSUE, DATA}.
- One sub-module, rr_arbiter: NM-bit request vector plus rr_ptr in, one-hot grant and encoded index out, purely combinational. Reused later for a write-channel arbiter.

Test Plan:
- Single request: master0 issues arid=4'h3, araddr=16'h0040, arlen=3 -> s_arvalid one cycle after the handshake with s_arid=8'h03; four beats reach only m_rvalid[0], each with rid=4'h3; last beat has m_rlast=1; back in IDLE the cycle after.
- Contention: both masters assert arvalid at reset release -> master0 granted first (s_arid=8'h0x), master1 next (s_arid=8'h1x); then with both still requesting, grants alternate 0,1,0,1.
- Backpressure: m_rready[1] toggles 1,0,0,1 during a 2-beat master1 burst -> s_rready mirrors it; s_rdata 32'hDEADBEEF held until accepted; master0 sees no rvalid.
- Slave stall: s_arready low for 5 cycles -> s_arvalid and s_ar_pld stable throughout; m_arready stays 0 for a master0 request arriving meanwhile.
- Reset mid-burst: reset low after the 2nd of 4 beats -> all outputs 0 the next cycle; after release, master1 is granted first (rr_ptr=0 but only master1 requesting), with correct s_arid=8'h1x.
- arlen=0 from master1, araddr=16'hFFFC -> one beat, m_rlast=1, m_rvalid[1] for exactly one cycle when m_rready=1.
